router_pkt_fsm: RTL and testbench
=================================

Name: router_pkt_fsm

Overview:
- Packet-sequencing controller for the 1-to-NUM_DEST router.
- Decodes the header address and waits for the destination FIFO to drain.
- Drives the phase strobes that steer the router register datapath: header load, payload load, full-stall hold, load-after-full, parity load and parity check.
- Also drives the write-enable to the FIFO synchroniser and the busy back-pressure signal to the source.

Parameters:
- NUM_DEST, 3: number of destination FIFOs (2..4); header address data_in[1:0] >= NUM_DEST is invalid.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  source indicates a valid packet byte.
- data_in  in  2  header address bits, data_in[1:0] of the byte bus.
- fifo_full  in  1  selected destination FIFO full.
- fifo_empty  in  NUM_DEST  per-destination FIFO empty flags.
- soft_reset  in  NUM_DEST  per-destination read-timeout soft resets.
- parity_done  in  1  parity byte captured by the register datapath.
- low_packet_valid  in  1  pkt_valid fell while the datapath was loading.
- detect_add  out  1  DECODE_ADDRESS phase.
- lfd_state  out  1  LOAD_FIRST_DATA phase.
- ld_state  out  1  LOAD_DATA phase.
- full_state  out  1  FIFO_FULL_STATE phase.
- laf_state  out  1  LOAD_AFTER_FULL phase.
- rst_int_reg  out  1  CHECK_PARITY_ERROR phase.
- write_enb_reg  out  1  write strobe to the destination FIFO.
- busy  out  1  back-pressure to the source.
- addr_q  out  2  latched destination address.

Behaviour:
- Registered state; all outputs are Moore, decoded combinationally from the state and addr_q.
- Reset (async, any time, including mid-packet):
  - state = DECODE_ADDRESS, addr_q = 0.
  - Resulting output values: detect_add = 1, all other strobes = 0, write_enb_reg = 0, busy = 0.
- addr_q loads data_in when state == DECODE_ADDRESS and pkt_valid = 1 and the address is valid. Otherwise it holds.
- Address validity: data_in < NUM_DEST.
- Transitions, evaluated each rising edge:
  - DECODE_ADDRESS:
    - pkt_valid & valid & fifo_empty[data_in] -> LOAD_FIRST_DATA.
    - pkt_valid & valid & ~fifo_empty[data_in] -> WAIT_TILL_EMPTY.
    - Otherwise (including an invalid address): stay. The invalid header is dropped silently.
  - WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE. fifo_full has priority over pkt_valid.
    - else ~pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: fifo_full -> stay; else LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_packet_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- Soft reset: in any state other than DECODE_ADDRESS, soft_reset[addr_q] = 1 forces next state = DECODE_ADDRESS. This overrides every transition above.
  - soft_reset bits of other destinations are ignored.
  - addr_q is not cleared.
- Output decode:
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = LOAD_FIRST_DATA | LOAD_PARITY | FIFO_FULL_STATE | LOAD_AFTER_FULL | WAIT_TILL_EMPTY | CHECK_PARITY_ERROR.
  - busy is 0 only in DECODE_ADDRESS and LOAD_DATA.
- Exactly one of the phase strobes is high in every state except WAIT_TILL_EMPTY and LOAD_PARITY, where all phase strobes are 0.
- Latency: a header accepted at edge N (empty FIFO) gives lfd_state high in cycle N+1 and ld_state high from N+2.
- State encoding is implementation choice. Unused encodings must recover to DECODE_ADDRESS.

Test Plan:
- Reset mid-packet:
  - Stimulus: assert reset asynchronously while in LOAD_DATA.
  - Required: state = DECODE_ADDRESS immediately, before the next edge; busy = 0; write_enb_reg = 0; addr_q = 0.
- Normal packet:
  - Stimulus: fifo_empty = 3'b111; header data_in = 2'b01 with pkt_valid for 1 cycle; 4 payload cycles; pkt_valid drops.
  - Required state sequence: DECODE, LFD, LD x4 (write_enb_reg = 1, busy = 0), LP (busy = 1), CPE (rst_int_reg = 1), DECODE.
  - Required: addr_q = 1 throughout.
- Wait for empty:
  - Stimulus: fifo_empty = 3'b011; header address 2; fifo_empty[2] rises after 5 cycles.
  - Required: WAIT_TILL_EMPTY for 5 cycles with busy = 1, then LFD.
- Full stall:
  - Stimulus: fifo_full = 1 for 3 cycles during LOAD_DATA, then 0; low_packet_valid = 0, parity_done = 0.
  - Required: FFS for 3 cycles (full_state = 1, write_enb_reg = 0), LAF for 1 cycle, back to LD.
  - Repeat with low_packet_valid = 1: required LAF -> LP. Repeat with parity_done = 1: required LAF -> DECODE.
- Invalid address:
  - Stimulus: header data_in = 2'b11 with pkt_valid, NUM_DEST = 3.
  - Required: FSM stays in DECODE, addr_q unchanged, busy = 0.
- Soft reset:
  - Stimulus A: addr_q = 0, soft_reset = 3'b001 during FFS. Required: DECODE next cycle.
  - Stimulus B: soft_reset = 3'b010 with addr_q = 0. Required: no effect.

Source files
------------

// File: rtl/router_pkt_fsm.sv
// Packet-sequencing controller for the 1-to-NUM_DEST router: header decode, FIFO-drain wait,
// and phase strobes for the register datapath, plus FIFO write-enable and source back-pressure.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a valid header byte
// WAIT_TILL_EMPTY    | header accepted, destination FIFO still draining
// LOAD_FIRST_DATA    | header byte loaded into the datapath
// LOAD_DATA          | payload bytes streaming into the FIFO
// FIFO_FULL_STATE    | destination full, datapath holds its byte
// LOAD_AFTER_FULL    | held byte written once the FIFO has room
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | parity compare, internal register reset
module router_pkt_fsm #(
  parameter int NUM_DEST = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pkt_valid,
  input  logic [1:0]          data_in,
  input  logic                fifo_full,
  input  logic [NUM_DEST-1:0] fifo_empty,
  input  logic [NUM_DEST-1:0] soft_reset,
  input  logic                parity_done,
  input  logic                low_packet_valid,
  output logic                detect_add,
  output logic                lfd_state,
  output logic                ld_state,
  output logic                full_state,
  output logic                laf_state,
  output logic                rst_int_reg,
  output logic                write_enb_reg,
  output logic                busy,
  output logic [1:0]          addr_q
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t     state, state_n;
  logic [1:0] addr_n;
  logic       hdr_valid, hdr_empty, addr_empty, addr_soft;

  assign hdr_valid = (32'(data_in) < NUM_DEST);

  // Per-destination selects via compare loop so an out-of-range address never indexes past the vector.
  always_comb begin
    hdr_empty  = 1'b0;
    addr_empty = 1'b0;
    addr_soft  = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (data_in == 2'(i)) hdr_empty = fifo_empty[i];
      if (addr_q == 2'(i)) begin
        addr_empty = fifo_empty[i];
        addr_soft  = soft_reset[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid && hdr_valid) begin
          addr_n  = data_in;
          state_n = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY:    state_n = addr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    state_n = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_n = FIFO_FULL_STATE;
        else if (!pkt_valid) state_n = LOAD_PARITY;
        else                 state_n = LOAD_DATA;
      end
      FIFO_FULL_STATE:    state_n = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_n = DECODE_ADDRESS;
        else if (low_packet_valid) state_n = LOAD_PARITY;
        else                       state_n = LOAD_DATA;
      end
      LOAD_PARITY:        state_n = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_n = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            state_n = DECODE_ADDRESS;
    endcase
    // A read-timeout on the active destination aborts the packet; addr_q is kept.
    if (state != DECODE_ADDRESS && addr_soft) state_n = DECODE_ADDRESS;
  end

  // Outputs are registered from the next state, so they always equal the decode of the current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= DECODE_ADDRESS;
      addr_q        <= 2'd0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      full_state    <= 1'b0;
      laf_state     <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      addr_q        <= addr_n;
      detect_add    <= (state_n == DECODE_ADDRESS);
      lfd_state     <= (state_n == LOAD_FIRST_DATA);
      ld_state      <= (state_n == LOAD_DATA);
      full_state    <= (state_n == FIFO_FULL_STATE);
      laf_state     <= (state_n == LOAD_AFTER_FULL);
      rst_int_reg   <= (state_n == CHECK_PARITY_ERROR);
      write_enb_reg <= (state_n == LOAD_DATA) || (state_n == LOAD_PARITY) ||
                       (state_n == LOAD_AFTER_FULL);
      busy          <= (state_n != DECODE_ADDRESS) && (state_n != LOAD_DATA);
    end
  end

endmodule

// File: tb/tb_router_pkt_fsm.sv
// Bench for router_pkt_fsm: directed test-plan scenarios with literal pins, then randomized
// stimulus, all checked every cycle against a phase-level reference model.
module tb_router_pkt_fsm;

  localparam int ND = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          pkt_valid;
  logic [1:0]    data_in;
  logic          fifo_full;
  logic [ND-1:0] fifo_empty;
  logic [ND-1:0] soft_reset;
  logic          parity_done;
  logic          low_packet_valid;
  logic          detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic          write_enb_reg, busy;
  logic [1:0]    addr_q;

  router_pkt_fsm #(.NUM_DEST(ND)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .addr_q(addr_q)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Packet phases of the reference model.
  localparam int P_DA = 0, P_WTE = 1, P_LFD = 2, P_LD = 3, P_FFS = 4, P_LAF = 5, P_LP = 6, P_CPE = 7;
  int         m_ph;
  logic [1:0] m_addr;

  // Output vector: {detect, lfd, ld, full, laf, rst_int, write_enb, busy, addr[1:0]}
  logic [9:0] dut_out;
  assign dut_out = {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
                    write_enb_reg, busy, addr_q};

  function automatic logic [9:0] model_out(int ph, logic [1:0] a);
    logic wr, bz;
    wr = (ph == P_LD) || (ph == P_LP) || (ph == P_LAF);
    bz = !((ph == P_DA) || (ph == P_LD));
    return {ph == P_DA, ph == P_LFD, ph == P_LD, ph == P_FFS, ph == P_LAF, ph == P_CPE, wr, bz, a};
  endfunction

  task automatic model_step();
    int nxt;
    if (reset) begin
      m_ph   = P_DA;
      m_addr = 2'd0;
      return;
    end
    nxt = m_ph;
    case (m_ph)
      P_DA:  if (pkt_valid && int'(data_in) < ND) begin
               nxt    = fifo_empty[data_in] ? P_LFD : P_WTE;
               m_addr = data_in;
             end
      P_WTE: if (fifo_empty[m_addr]) nxt = P_LFD;
      P_LFD: nxt = P_LD;
      P_LD:  nxt = fifo_full ? P_FFS : (pkt_valid ? P_LD : P_LP);
      P_FFS: nxt = fifo_full ? P_FFS : P_LAF;
      P_LAF: nxt = parity_done ? P_DA : (low_packet_valid ? P_LP : P_LD);
      P_LP:  nxt = P_CPE;
      P_CPE: nxt = fifo_full ? P_FFS : P_DA;
      default: nxt = P_DA;
    endcase
    if (m_ph != P_DA && soft_reset[m_addr]) nxt = P_DA;
    m_ph = nxt;
  endtask

  task automatic check_model(string tag);
    logic [9:0] exp;
    exp = model_out(m_ph, m_addr);
    n_cmp++;
    if (dut_out !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: dut=%b model=%b", tag, $time, dut_out, exp);
    end
  endtask

  // Hand-computed literal: pins both the DUT and the model.
  task automatic check_lit(string tag, logic [9:0] exp);
    n_cmp++;
    if (dut_out !== exp) begin
      n_bad++;
      $display("FAIL %s dut @%0t: got=%b want=%b", tag, $time, dut_out, exp);
    end
    n_cmp++;
    if (model_out(m_ph, m_addr) !== exp) begin
      n_bad++;
      $display("FAIL %s model @%0t: got=%b want=%b", tag, $time, model_out(m_ph, m_addr), exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_model("cycle");
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    m_ph   = P_DA;
    m_addr = 2'd0;
    check_model("async_reset");
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 0; data_in = 0; fifo_full = 0; fifo_empty = '1;
    soft_reset = '0; parity_done = 0; low_packet_valid = 0;
    m_ph = P_DA; m_addr = 2'd0;
    @(negedge clock);
    check_lit("reset_state", 10'b1000000000);
    reset = 1'b0;

    // Normal packet to destination 1
    fifo_empty = 3'b111; data_in = 2'd1; pkt_valid = 1;
    tick(); check_lit("lfd", 10'b0100000101);
    data_in = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick(); check_lit("ld_payload", 10'b0010001001);
    end
    pkt_valid = 0;
    tick(); check_lit("lp", 10'b0000001101);
    tick(); check_lit("cpe", 10'b0000010101);
    tick(); check_lit("back_to_da", 10'b1000000001);

    // Invalid header address is dropped, addr_q holds
    data_in = 2'd3; pkt_valid = 1;
    tick(); check_lit("invalid_addr", 10'b1000000001);
    tick(); check_lit("invalid_addr2", 10'b1000000001);

    // Wait for destination 2 to drain
    fifo_empty = 3'b011; data_in = 2'd2;
    tick(); check_lit("wte", 10'b0000000110);
    pkt_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); check_lit("wte_hold", 10'b0000000110);
    end
    fifo_empty = 3'b111;
    tick(); check_lit("wte_to_lfd", 10'b0100000110);
    repeat (4) tick();

    // Full stall on destination 0: LAF -> LD
    data_in = 2'd0; pkt_valid = 1;
    tick(); tick();
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_lit("ffs", 10'b0001000100);
    end
    fifo_full = 0;
    tick(); check_lit("laf", 10'b0000101100);
    tick(); check_lit("laf_to_ld", 10'b0010001000);
    // LAF -> LP on low_packet_valid
    fifo_full = 1; tick();
    fifo_full = 0; tick();
    low_packet_valid = 1;
    tick(); check_lit("laf_to_lp", 10'b0000001100);
    low_packet_valid = 0; pkt_valid = 0;
    tick(); tick();
    // LAF -> DA on parity_done
    pkt_valid = 1; tick(); tick();
    fifo_full = 1; tick();
    fifo_full = 0; tick(); check_lit("laf2", 10'b0000101100);
    parity_done = 1;
    tick(); check_lit("laf_to_da", 10'b1000000000);
    parity_done = 0;

    // Soft reset A: own destination during FFS aborts
    tick(); tick(); fifo_full = 1; tick();
    soft_reset = 3'b001;
    tick(); check_lit("soft_reset_own", 10'b1000000000);
    // Soft reset B: other destination has no effect
    soft_reset = 3'b010; fifo_full = 0;
    tick(); check_lit("soft_reset_other_lfd", 10'b0100000100);
    tick(); check_lit("soft_reset_other_ld", 10'b0010001000);
    soft_reset = 3'b000; pkt_valid = 0;
    tick(); tick(); tick();

    // Async reset mid-packet with addr_q = 1
    data_in = 2'd1; pkt_valid = 1;
    tick(); tick(); check_lit("pre_reset_ld", 10'b0010001001);
    #2 reset = 1'b1;
    #1;
    m_ph = P_DA; m_addr = 2'd0;
    check_lit("async_reset_mid_packet", 10'b1000000000);
    tick();
    reset = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pkt_valid        = ($urandom_range(0, 9) < 8);
      data_in          = 2'($urandom_range(0, 3));
      fifo_full        = ($urandom_range(0, 9) < 2);
      fifo_empty       = ND'($urandom);
      soft_reset       = ($urandom_range(0, 29) == 0) ? ND'($urandom) : '0;
      parity_done      = ($urandom_range(0, 9) < 2);
      low_packet_valid = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
